// File: rtl/rv_instr_encoder.sv
// rv_instr_encoder: streaming RV32I field-bundle to machine-word encoder.
// One-deep output register behind a valid/ready handshake. Each emitted word
// carries the instruction-memory address it belongs at.
// Optional build macro: IMM_RANGE_CHECK_EN (drops out-of-range immediates, sets err).
module rv_instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [20:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic [15:0]       out_count,
  output logic              err
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_count;
  logic [31:0]       w_enc;
  logic              w_accept;
  logic              w_emit;
  logic              w_load;
  logic              w_imm_bad;
  logic              w_is_shift;

  assign out_valid  = (r_state == S_FULL);
  assign in_ready   = !out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_emit     = out_valid && out_ready;
  assign w_load     = w_accept && !w_imm_bad;
  assign w_is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  assign out_instr = r_instr;
  assign out_addr  = r_addr;
  assign out_count = r_count;

  // Pack the incoming field bundle into an RV32I machine word.
  always_comb begin
    w_enc = NOP_WORD;
    case (in_kind)
      3'd0: w_enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, OP_LOAD};
      3'd1: w_enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], OP_STORE};
      3'd2: w_enc = {1'b0, in_funct7b5, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_REG};
      3'd3: w_enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], OP_BRANCH};
      3'd4: begin
        if (w_is_shift)
          w_enc = {1'b0, in_funct7b5, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd, OP_IMM};
        else
          w_enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_IMM};
      end
      3'd5: w_enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
      3'd6: w_enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR};
      default: w_enc = NOP_WORD;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic signed [20:0] w_simm;
  logic               r_err;

  assign w_simm = $signed(in_imm);
  assign err    = r_err;

  // Flag immediates that do not fit the encoding of the selected kind.
  always_comb begin
    w_imm_bad = 1'b0;
    case (in_kind)
      3'd0, 3'd1, 3'd6:
        w_imm_bad = (w_simm < -21'sd2048) || (w_simm > 21'sd2047);
      3'd3:
        w_imm_bad = (w_simm < -21'sd4096) || (w_simm > 21'sd4094) || in_imm[0];
      3'd4: begin
        if (w_is_shift)
          w_imm_bad = (w_simm < 21'sd0) || (w_simm > 21'sd31);
        else
          w_imm_bad = (w_simm < -21'sd2048) || (w_simm > 21'sd2047);
      end
      3'd5:
        w_imm_bad = in_imm[0];
      default:
        w_imm_bad = 1'b0;
    endcase
  end

  // Sticky error: set by any accepted-but-dropped bundle, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset_n)
      r_err <= 1'b0;
    else if (w_accept && w_imm_bad)
      r_err <= 1'b1;
  end
`else
  logic w_unused_imm0;

  assign w_imm_bad     = 1'b0;
  assign err           = 1'b0;
  assign w_unused_imm0 = in_imm[0];
`endif

  // EMPTY/FULL state register.
  always_ff @(posedge clk) begin
    if (!reset_n)
      r_state <= S_EMPTY;
    else
      r_state <= w_state_nxt;
  end

  // Next state: fill on a kept accept, drain on emit with nothing replacing it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_load) w_state_nxt = S_FULL;
      S_FULL:  if (w_emit && !w_load) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Output word, address counter and saturating emit counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_instr <= '0;
      r_addr  <= BASE_ADDR;
      r_count <= '0;
    end else begin
      if (w_load)
        r_instr <= w_enc;
      if (w_emit) begin
        r_addr <= r_addr + ADDR_W'(4);
        if (r_count != '1)
          r_count <= r_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Self-checking bench for rv_instr_encoder: directed cases then random traffic,
// compared against an arithmetic reference model of the encoding rules.
module tb_rv_instr_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [20:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [15:0] out_count;
  logic        err;

  logic        w2_in_ready;
  logic        w2_out_valid;
  logic [31:0] w2_out_instr;
  logic [3:0]  w2_out_addr;
  logic [15:0] w2_out_count;
  logic        w2_err;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        m_valid;
  logic        m_known;
  logic [31:0] m_instr;
  logic [31:0] m_addr;
  logic [3:0]  m_addr2;
  int          m_cnt;
  logic        m_err;

  always #5 clk = ~clk;

  rv_instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_addr(out_addr), .out_count(out_count), .err(err)
  );

  rv_instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'hC)) dut_w4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(w2_in_ready),
    .in_kind(in_kind), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(w2_out_valid), .out_ready(out_ready), .out_instr(w2_out_instr),
    .out_addr(w2_out_addr), .out_count(w2_out_count), .err(w2_err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Encoding computed by shifting and masking an integer immediate.
  function automatic logic [31:0] ref_enc(input int kind, input int f3, input int f7,
                                          input int rd, input int rs1, input int rs2,
                                          input int imm);
    logic [31:0] u;
    u = imm;
    case (kind)
      0: return ((u & 32'hFFF) << 20) | (rs1 << 15) | (2 << 12) | (rd << 7) | 3;
      1: return (((u >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (2 << 12)
                | ((u & 31) << 7) | 35;
      2: return (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 51;
      3: return (((u >> 12) & 1) << 31) | (((u >> 5) & 63) << 25) | (rs2 << 20)
                | (rs1 << 15) | (f3 << 12) | (((u >> 1) & 15) << 8)
                | (((u >> 11) & 1) << 7) | 99;
      4: begin
        if (f3 == 1 || f3 == 5)
          return (f7 << 30) | ((u & 31) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 19;
        return ((u & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 19;
      end
      5: return (((u >> 20) & 1) << 31) | (((u >> 1) & 1023) << 21) | (((u >> 11) & 1) << 20)
                | (((u >> 12) & 255) << 12) | (rd << 7) | 111;
      6: return ((u & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 103;
      default: return 32'h0000_0013;
    endcase
  endfunction

  function automatic logic ref_bad(input int kind, input int f3, input int imm);
`ifdef IMM_RANGE_CHECK_EN
    case (kind)
      0, 1, 6: return (imm < -2048) || (imm > 2047);
      3: return (imm < -4096) || (imm > 4094) || ((imm & 1) != 0);
      4: begin
        if (f3 == 1 || f3 == 5) return (imm < 0) || (imm > 31);
        return (imm < -2048) || (imm > 2047);
      end
      5: return (imm & 1) != 0;
      default: return 1'b0;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: drive at negedge, check in_ready, advance model, check outputs.
  task automatic step(input logic rst_n, input logic v, input logic rdy, input int k,
                      input int f3, input int f7, input int rd, input int rs1,
                      input int rs2, input int imm);
    logic exp_ready, acc, emit, drop;
    @(negedge clk);
    reset_n     = rst_n;
    in_valid    = v;
    out_ready   = rdy;
    in_kind     = 3'(k);
    in_funct3   = 3'(f3);
    in_funct7b5 = 1'(f7);
    in_rd       = 5'(rd);
    in_rs1      = 5'(rs1);
    in_rs2      = 5'(rs2);
    in_imm      = 21'(imm);
    #1;
    exp_ready = !m_valid || rdy;
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    acc  = v && exp_ready;
    emit = m_valid && rdy;
    drop = ref_bad(k, f3, imm);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_valid = 1'b0; m_known = 1'b1; m_instr = '0;
      m_addr = 32'h0; m_addr2 = 4'hC; m_cnt = 0; m_err = 1'b0;
    end else begin
      if (acc && drop) m_err = 1'b1;
      if (emit) begin
        m_addr  = m_addr + 4;
        m_addr2 = m_addr2 + 4'd4;
        if (m_cnt < 65535) m_cnt++;
      end
      if (acc && !drop) begin
        m_instr = ref_enc(k, f3, f7, rd, rs1, rs2, imm);
        m_valid = 1'b1;
        m_known = 1'b1;
      end else if (emit) begin
        m_valid = 1'b0;
        m_known = 1'b0;
      end
    end
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("out_addr", out_addr, m_addr);
    chk("out_addr_w4", {28'b0, w2_out_addr}, {28'b0, m_addr2});
    chk("out_count", {16'b0, out_count}, m_cnt);
    chk("err", {31'b0, err}, {31'b0, m_err});
    if (m_known) chk("out_instr", out_instr, m_instr);
  endtask

  task automatic idle(input logic rdy);
    step(1'b1, 1'b0, rdy, 7, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    m_valid = 1'b0; m_known = 1'b0; m_instr = '0;
    m_addr = 32'h0; m_addr2 = 4'hC; m_cnt = 0; m_err = 1'b0;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_kind = '0; in_funct3 = '0; in_funct7b5 = 1'b0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;

    step(1'b0, 1'b0, 1'b0, 7, 0, 0, 0, 0, 0, 0);
    step(1'b0, 1'b1, 1'b1, 2, 0, 0, 1, 2, 3, 0);
    chk("reset_instr", out_instr, 32'h0);

    // addi x1,x0,5 ; then back-to-back lw/sw/add/sub with out_ready=1
    step(1'b1, 1'b1, 1'b1, 4, 0, 0, 1, 0, 0, 5);
    chk("addi", out_instr, 32'h0050_0093);
    step(1'b1, 1'b1, 1'b1, 0, 0, 0, 6, 9, 0, -4);
    chk("lw", out_instr, 32'hFFC4_A303);
    step(1'b1, 1'b1, 1'b1, 1, 0, 0, 0, 9, 6, 8);
    chk("sw", out_instr, 32'h0064_A423);
    step(1'b1, 1'b1, 1'b1, 2, 0, 0, 3, 1, 2, 0);
    chk("add", out_instr, 32'h0020_81B3);
    step(1'b1, 1'b1, 1'b1, 2, 0, 1, 3, 1, 2, 0);
    chk("sub", out_instr, 32'h4020_81B3);
    step(1'b1, 1'b1, 1'b1, 5, 0, 0, 1, 0, 0, 8);
    chk("jal", out_instr, 32'h0080_00EF);
    step(1'b1, 1'b1, 1'b1, 3, 0, 0, 0, 4, 4, -4);
    chk("beq", out_instr, 32'hFE42_0EE3);
    step(1'b1, 1'b1, 1'b1, 7, 0, 0, 9, 9, 9, 123);
    chk("nop", out_instr, 32'h0000_0013);
    idle(1'b1);

    // Stall three cycles while full, then emit and accept in the same edge
    step(1'b1, 1'b1, 1'b0, 4, 5, 1, 7, 8, 0, 3);
    chk("srai", out_instr, 32'h4034_5393);
    step(1'b1, 1'b1, 1'b0, 2, 7, 0, 1, 1, 1, 0);
    step(1'b1, 1'b1, 1'b0, 2, 7, 0, 1, 1, 1, 0);
    step(1'b1, 1'b1, 1'b0, 2, 7, 0, 1, 1, 1, 0);
    step(1'b1, 1'b1, 1'b1, 6, 0, 0, 1, 5, 0, 16);
    idle(1'b1);

    // Out-of-range immediates: dropped with the check, truncated without
    step(1'b1, 1'b1, 1'b1, 3, 0, 0, 0, 1, 2, 3);
    step(1'b1, 1'b1, 1'b1, 0, 0, 0, 1, 2, 0, 4096);
    idle(1'b1);

    // Reset while full
    step(1'b1, 1'b1, 1'b0, 2, 0, 0, 3, 4, 5, 0);
    step(1'b0, 1'b0, 1'b0, 7, 0, 0, 0, 0, 0, 0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      int k, f3, imm;
      logic [20:0] r21;
      logic rst_n;
      k  = $urandom_range(0, 7);
      f3 = $urandom_range(0, 7);
      r21 = 21'($urandom);
      case ($urandom_range(0, 3))
        0: imm = int'($signed(r21));
        1: imm = $urandom_range(0, 40);
        default: imm = $urandom_range(0, 8000) - 4000;
      endcase
      rst_n = ($urandom_range(0, 99) != 0);
      step(rst_n, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7), k, f3,
           $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), imm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_instr_encoder.md
Name: rv_instr_encoder

Overview:
Streaming RISC-V RV32I instruction encoder, the inverse of the control decoder. Accepts decoded instruction fields (kind, funct3, registers, immediate) over a valid/ready handshake. Packs each into a 32-bit machine word, registers it, and emits it with its target instruction-memory address. Used by the boot/program loader and by the testbench to fill instruction memory without external assembled images.

Parameters:
ADDR_W, 32, width of out_addr and the address counter
BASE_ADDR, 32'h0000_0000, address of the first emitted word after reset; must be 4-byte aligned

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  reset, synchronous, active-low
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept a bundle this cycle
in_kind  in  3  0=lw 1=sw 2=R 3=B 4=I-ALU 5=jal 6=jalr 7=nop
in_funct3  in  3  funct3 for R/B/I-ALU; ignored for other kinds
in_funct7b5  in  1  bit 30 for R, and for I-ALU shifts with funct3=101
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_imm  in  21  signed immediate, byte offset
out_valid  out  1  encoded word valid
out_ready  in  1  consumer accepts word
out_instr  out  32  encoded instruction
out_addr  out  ADDR_W  memory address of out_instr
out_count  out  16  words emitted since reset; saturates at 16'hFFFF
err  out  1  sticky immediate-range error (see Optional Feature)

Behaviour:
- Reset (reset_n=0 at clk edge): out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_count=0, err=0. Reset mid-transfer discards any held word; no partial handshake survives.
- in_ready = !out_valid | out_ready (combinational). Acceptance = in_valid & in_ready.
- Latency 1: word accepted at edge N is on out_instr with out_valid=1 after edge N. Full throughput of 1 word/cycle when out_ready=1.
- Output register holds out_instr and out_addr stable while out_valid & !out_ready.
- Emit handshake = out_valid & out_ready. On each emit, out_addr += 4 (mod 2^ADDR_W, wraps silently) and out_count += 1 (saturating).
- Simultaneous emit and accept: the new word loads and the address advances in the same edge. out_valid stays 1.
- Emit with no accept: out_valid -> 0.
- Two-state view: EMPTY (out_valid=0) and FULL (out_valid=1). EMPTY->FULL on accept. FULL->EMPTY on emit without accept. FULL->FULL on emit+accept or on stall.
- Encodings (imm = in_imm):
  - lw: imm[11:0], rs1, 010, rd, 0000011
  - sw: imm[11:5], rs2, rs1, 010, imm[4:0], 0100011
  - R: 0,f7b5,00000, rs2, rs1, funct3, rd, 0110011
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011
  - I-ALU: imm[11:0], rs1, funct3, rd, 0010011. When funct3=001 or 101, bits[31:25] = 0,f7b5,00000 and bits[24:20] = imm[4:0].
  - jal: imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111
  - jalr: imm[11:0], rs1, 000, rd, 1100111
  - nop: 32'h0000_0013
- Unused immediate bits are truncated. The encoder never emits an opcode outside the seven the decoder implements.

Optional Feature:
IMM_RANGE_CHECK_EN
- Defined: at acceptance, check in_imm range per kind:
  - lw, sw, I-ALU, jalr: -2048..2047
  - I-ALU shifts: 0..31
  - B: -4096..4094, must be even
  - jal: full 21-bit range, must be even
- A failing bundle is still accepted (in_ready unchanged) but is dropped: no output word, no address advance, and err set to 1 until reset.
- Not defined: no check, silent truncation, err tied to 0.

Test Plan:
- After reset, addi x1,x0,5 (kind4, f3=000, rd1, rs1 0, imm5) -> out_instr=0x00500093, out_addr=BASE_ADDR, out_valid 1 cycle later.
- Back-to-back with out_ready=1: lw x6,-4(x9), then sw x6,8(x9), then add x3,x1,x2, then sub x3,x1,x2 -> 0xFFC4A303, 0x0064A423, 0x002081B3, 0x402081B3 at addrs +0,+4,+8,+C; out_count=4.
- jal x1,8 -> 0x008000EF. beq x4,x4,-4 (f3=000, imm=-4) -> 0xFE420EE3. Nop -> 0x00000013.
- Hold out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_instr/out_addr stable, no count change. Release -> emit and next accept in the same edge.
- ADDR_W=4, BASE_ADDR=4'hC: emit two words -> out_addr 0xC then 0x0 (wrap). Assert reset_n=0 while FULL -> out_valid=0, out_addr=0xC next cycle.
- With IMM_RANGE_CHECK_EN: B with imm=3, then lw with imm=4096 -> both dropped, err=1, out_addr unchanged. Without the macro: both emitted truncated, err=0.
